// File: rtl/cpu_pkg.sv
// Constants shared by the fetch front end: PC step and default reset vector.
package cpu_pkg;

   localparam int unsigned PC_INC = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered pointers, head visible combinationally (0-cycle read).
// Push is ignored when full, pop when empty; flush empties it on the next clock edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_dat_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign push_ok    = push_i && (count_q != (AW+1)'(DEPTH));
   assign pop_ok     = pop_i && (count_q != '0);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   // Storage needs no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Credit-limited instruction fetcher feeding an in-order queue; response to out_valid in 1 cycle.
// Requests stall when queued + live in-flight fetches reach DEPTH; redirect flushes and drops stale responses.
module instr_fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned         PC_WIDTH    = 32,
   parameter int unsigned         INSTR_WIDTH = 32,
   parameter int unsigned         DEPTH       = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [PC_WIDTH-1:0]        imem_req_addr,
   input  logic                       imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0]     imem_rsp_data,
   input  logic                       redirect_valid,
   input  logic [PC_WIDTH-1:0]        redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INSTR_WIDTH-1:0]     out_instr,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = CW + 3;
   localparam int EW = PC_WIDTH + INSTR_WIDTH;

   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
   logic [OW-1:0]       outs_q, outs_d;
   logic [OW-1:0]       drop_q, drop_d;
   logic [OW-1:0]       live_outs;
   logic                credit_ok, req_hs, rsp_ok, enq, deq;
   logic [EW-1:0]       head_dat;

   assign live_outs = outs_q - drop_q;
   // Dropped fetches hold no queue slot, so only live ones count against the credit.
   // The all-ones check keeps outs_q from wrapping if a memory never drains dropped fetches.
   assign credit_ok = ((OW'(occupancy) + live_outs) < OW'(DEPTH)) && (outs_q != {OW{1'b1}});

   assign imem_req_valid = !rst && !redirect_valid && credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;

   assign rsp_ok = imem_rsp_valid && (outs_q != '0);
   assign enq    = rsp_ok && !redirect_valid && (drop_q == '0);

   assign out_valid = (occupancy != '0) && !redirect_valid;
   assign deq       = out_valid && out_ready;
   assign out_pc    = head_dat[EW-1 -: PC_WIDTH];
   assign out_instr = head_dat[INSTR_WIDTH-1:0];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      outs_d     = outs_q + OW'(req_hs) - OW'(rsp_ok);
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         drop_d     = outs_q - OW'(rsp_ok);
      end else begin
         if (req_hs) fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_INC);
         if (rsp_ok) begin
            if (drop_q != '0) drop_d   = drop_q - OW'(1);
            else              rsp_pc_d = rsp_pc_q + PC_WIDTH'(PC_INC);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outs_q     <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outs_q     <= outs_d;
         drop_q     <= drop_d;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (redirect_valid),
      .push_i     (enq),
      .push_dat_i ({rsp_pc_q, imem_rsp_data}),
      .pop_i      (deq),
      .head_dat_o (head_dat),
      .count_o    (occupancy)
   );

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (outs_q == '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench: in-order memory, request/entry queues as the reference model.
module tb_instr_fetch_queue;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_instr, out_pc;
   logic [2:0]  occupancy;

   always #5 clk = ~clk;

   instr_fetch_queue #(
      .PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(D), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
   );

   typedef struct { logic [31:0] addr; bit dropped; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

   req_t        inflight[$];
   ent_t        fq[$];
   logic [31:0] m_fetch_pc;
   logic [31:0] hs_addrs[$];
   int          hs_cnt;
   int          checks = 0;
   int          errors = 0;

   logic        obs_rv, obs_ov;
   logic [31:0] obs_addr, obs_pc;
   logic [2:0]  obs_occ;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance the model.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                       input bit ordy, input bit rv_want);
      int   live;
      bit   exp_rv, exp_ov;
      req_t r;
      @(negedge clk);
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      out_ready      = ordy;
      imem_rsp_valid = rv_want && (inflight.size() != 0);
      imem_rsp_data  = $urandom;
      #1;
      live = 0;
      foreach (inflight[i]) if (!inflight[i].dropped) live++;
      exp_rv = !redir && ((fq.size() + live) < D);
      exp_ov = (fq.size() != 0) && !redir;
      chk("req_valid", imem_req_valid, exp_rv);
      chk("req_addr", imem_req_addr, m_fetch_pc);
      chk("out_valid", out_valid, exp_ov);
      chk("occupancy", occupancy, fq.size());
      if (exp_ov) begin
         chk("out_pc", out_pc, fq[0].pc);
         chk("out_instr", out_instr, fq[0].instr);
      end
      obs_rv = imem_req_valid; obs_ov = out_valid; obs_addr = imem_req_addr;
      obs_pc = out_pc; obs_occ = occupancy;
      if (exp_ov && ordy) void'(fq.pop_front());
      if (imem_rsp_valid) begin
         r = inflight.pop_front();
         if (!redir && !r.dropped) fq.push_back('{r.addr, imem_rsp_data});
      end
      if (redir) begin
         fq.delete();
         foreach (inflight[i]) inflight[i].dropped = 1'b1;
         m_fetch_pc = rpc;
      end else if (exp_rv && rdy) begin
         inflight.push_back('{m_fetch_pc, 1'b0});
         hs_addrs.push_back(m_fetch_pc);
         hs_cnt++;
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
   endtask

   task automatic do_reset(input bit check_now);
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0;
      #1;
      if (check_now) begin
         chk("rst_occupancy", occupancy, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_req_valid", imem_req_valid, 0);
         chk("rst_req_addr", imem_req_addr, 32'h0);
      end
      fq.delete(); inflight.delete(); hs_addrs.delete();
      m_fetch_pc = 32'h0; hs_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit          found;
      logic [31:0] first_pc;
      logic [31:0] opcs[$];

      // Streaming fill: two cycles to first instruction, then one per cycle.
      do_reset(1);
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 1, 1, 1);
         if (k < 2) chk("fill_idle", obs_ov, 0);
         else begin
            chk("fill_valid", obs_ov, 1);
            chk("fill_pc", obs_pc, 32'(4 * (k - 2)));
         end
      end

      // Decode stalled: exactly DEPTH fetches, then requests held until a dequeue.
      do_reset(0);
      for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 1);
      chk("stall_hs_count", hs_cnt, 4);
      chk("stall_occ", obs_occ, 4);
      chk("stall_req_low", obs_rv, 0);
      step(0, 0, 1, 1, 0);
      chk("stall_deq_req_low", obs_rv, 0);
      step(0, 0, 1, 0, 0);
      chk("stall_after_deq_req", obs_rv, 1);
      chk("stall_after_deq_occ", obs_occ, 3);

      // Redirect with two responses outstanding.
      do_reset(0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("redir_inflight", hs_cnt, 2);
      step(1, 32'h100, 1, 0, 0);
      found = 0; first_pc = '0;
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 1, 1, 1);
         if (obs_ov && !found) begin found = 1; first_pc = obs_pc; end
      end
      chk("redir_seen", found, 1);
      chk("redir_first_pc", first_pc, 32'h100);

      // Memory stall holds the address; redirect during stall retargets it.
      do_reset(0);
      step(0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, 1);
         chk("stall_addr", obs_addr, 32'h4);
      end
      step(1, 32'h200, 0, 1, 0);
      chk("stall_redir_addr_old", obs_addr, 32'h4);
      step(0, 0, 0, 1, 0);
      chk("stall_redir_addr_new", obs_addr, 32'h200);

      // PC wrap-around on both the fetch address and the delivered PC.
      do_reset(0);
      step(1, 32'hFFFF_FFF8, 0, 1, 0);
      for (int k = 0; k < 8; k++) begin
         step(0, 0, 1, 1, 1);
         if (obs_ov) opcs.push_back(obs_pc);
      end
      chk("wrap_hs_enough", hs_addrs.size() >= 3, 1);
      chk("wrap_out_enough", opcs.size() >= 3, 1);
      if (hs_addrs.size() >= 3 && opcs.size() >= 3) begin
         chk("wrap_addr1", hs_addrs[1], 32'hFFFF_FFFC);
         chk("wrap_addr2", hs_addrs[2], 32'h0);
         chk("wrap_pc1", opcs[1], 32'hFFFF_FFFC);
         chk("wrap_pc2", opcs[2], 32'h0);
      end

      // Reset while three entries are queued and one response is pending.
      do_reset(0);
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         step(0, 0, 1, 0, 1);
         found = (fq.size() == 3) && (inflight.size() == 1);
      end
      chk("midrst_setup", found, 1);
      do_reset(1);
      step(0, 0, 1, 0, 0);
      chk("midrst_req_valid", obs_rv, 1);
      chk("midrst_req_addr", obs_addr, 32'h0);

      // Random traffic.
      do_reset(0);
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] rpc;
         if (n % 700 == 699) do_reset(1);
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                           : ($urandom & 32'h0000_FFFC);
         step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
